tdm_rx_deframer: RTL and testbench



---
 rtl/tdm_pkg.sv | 23 ++
 rtl/tdm_slot_counter.sv | 32 +++
 rtl/tdm_rx_deframer.sv | 171 +++++++++++++++++
 tb/tb_tdm_rx_deframer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link (receiver and transmitter):
// lock states, default channel count, slot-index width and parity helper.
package tdm_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int NUM_CH_DEFAULT = 4;

  // Width of a slot index for a frame of frame_len slots (at least one bit).
  function automatic int slot_width(input int frame_len);
    return (frame_len > 2) ? $clog2(frame_len) : 1;
  endfunction

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrap-around slot counter; load forces the next value to 1 (realign after a
// slot-0 sample), hold parks it at 0 while hunting.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int FRAME_LEN = NUM_CH_DEFAULT,
  parameter int SLOT_W    = slot_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              hold,
  output logic [SLOT_W-1:0] slot
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (load) begin
      slot <= SLOT_W'(1);
    end else if (hold) begin
      slot <= '0;
    end else if (slot == SLOT_W'(FRAME_LEN - 1)) begin
      slot <= '0;
    end else begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_rx_deframer.sv
// TDM receive deframer: FSYNC alignment, HUNT/VERIFY/LOCKED lock FSM, serial to
// parallel frame delivery. Define TDM_RX_PARITY_EN for a trailing even-parity slot.
module tdm_rx_deframer
  import tdm_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEFAULT,
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_FRAMES = 2,
`ifdef TDM_RX_PARITY_EN
  localparam int FRAME_LEN  = NUM_CH + 1,
`else
  localparam int FRAME_LEN  = NUM_CH,
`endif
  localparam int SLOT_W     = slot_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              fsync,
  output logic [NUM_CH-1:0] y,
  output logic              frame_valid,
  output logic              locked,
  output logic [SLOT_W-1:0] slot,
`ifdef TDM_RX_PARITY_EN
  output logic              par_err,
`endif
  output logic              sync_err
);

`ifdef TDM_RX_PARITY_EN
  localparam int SHADOW_W = NUM_CH;
`else
  // The last data bit goes straight from din into y, so it is never stored.
  localparam int SHADOW_W = NUM_CH - 1;
`endif
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W = $clog2(LOSS_FRAMES + 1);
  localparam state_t ALIGN_STATE = (LOCK_FRAMES > 1) ? VERIFY : LOCKED;

  state_t              state;
  logic [SHADOW_W-1:0] shadow;
  logic [GOOD_W-1:0]   good;
  logic [MISS_W-1:0]   miss;
  logic                frame_ok;   // current frame started while already locked

  logic                at_first;
  logic                at_last;
  logic                good_done;
  logic                miss_done;
  logic                ctr_load;
  logic                ctr_hold;
  logic                shadow_we;
  logic [SLOT_W-1:0]   shadow_idx;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    at_first   = (slot == '0);
    at_last    = (slot == SLOT_W'(FRAME_LEN - 1));
    good_done  = (int'(good) + 1 >= LOCK_FRAMES);
    miss_done  = (int'(miss) + 1 >= LOSS_FRAMES);
    ctr_load   = fsync;
    ctr_hold   = 1'b0;
    if (!fsync) begin
      ctr_hold = (state == HUNT) ||
                 (at_first && ((state == VERIFY) || ((state == LOCKED) && miss_done)));
    end
    shadow_we  = fsync || (state != HUNT);
    shadow_idx = fsync ? '0 : slot;
  end

  tdm_slot_counter #(
    .FRAME_LEN (FRAME_LEN),
    .SLOT_W    (SLOT_W)
  ) u_slot_counter (
    .clk  (clk),
    .rst  (rst),
    .load (ctr_load),
    .hold (ctr_hold),
    .slot (slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: shadow is a small flop vector, not a RAM, so clearing it on reset
      // is cheap and keeps a stale partial frame from surviving reset.
      state       <= HUNT;
      locked      <= 1'b0;
      shadow      <= '0;
      good        <= '0;
      miss        <= '0;
      frame_ok    <= 1'b0;
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
      for (int k = 0; k < SHADOW_W; k++) begin
        if (shadow_we && (shadow_idx == SLOT_W'(k))) shadow[k] <= din;
      end

      case (state)
        HUNT: begin
          if (fsync) begin
            good     <= GOOD_W'(1);
            miss     <= '0;
            frame_ok <= 1'b0;
            state    <= ALIGN_STATE;
            locked   <= (ALIGN_STATE == LOCKED);
          end
        end
        default: begin
          if (fsync && !at_first) begin
            // Misplaced marker: restart the frame here, partial frame dropped.
            sync_err <= 1'b1;
            good     <= GOOD_W'(1);
            miss     <= '0;
            frame_ok <= 1'b0;
            state    <= ALIGN_STATE;
            locked   <= (ALIGN_STATE == LOCKED);
          end else if (at_first && fsync) begin
            miss <= '0;
            if (state == VERIFY) begin
              frame_ok <= 1'b0;
              good     <= good + GOOD_W'(1);
              if (good_done) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              frame_ok <= 1'b1;
            end
          end else if (at_first) begin
            sync_err <= 1'b1;
            if ((state == VERIFY) || miss_done) begin
              state    <= HUNT;
              locked   <= 1'b0;
              good     <= '0;
              miss     <= '0;
              frame_ok <= 1'b0;
            end else begin
              // Flywheel through a lone missing marker.
              miss     <= miss + MISS_W'(1);
              frame_ok <= 1'b1;
            end
          end else if (at_last && (state == LOCKED) && frame_ok) begin
`ifdef TDM_RX_PARITY_EN
            if (din == even_parity(32'(shadow))) begin
              y           <= shadow;
              frame_valid <= 1'b1;
            end else begin
              par_err     <= 1'b1;
            end
`else
            y           <= {din, shadow};
            frame_valid <= 1'b1;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_rx_deframer.sv
// Scoreboard bench for tdm_rx_deframer: a frame-position reference model queues
// expected events per clock edge; a monitor compares the DUT outputs against them.
module tb_tdm_rx_deframer;
  import tdm_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int LOCK_FRAMES = 2;
  localparam int LOSS_FRAMES = 2;
`ifdef TDM_RX_PARITY_EN
  localparam int FL = NUM_CH + 1;
`else
  localparam int FL = NUM_CH;
`endif
  localparam int SW = slot_width(FL);

  logic              clk = 1'b0;
  logic              rst;
  logic              din;
  logic              fsync;
  logic [NUM_CH-1:0] y;
  logic              frame_valid;
  logic              locked;
  logic [SW-1:0]     slot;
  logic              sync_err;
`ifdef TDM_RX_PARITY_EN
  logic              par_err;
`endif

  tdm_rx_deframer #(
    .NUM_CH      (NUM_CH),
    .LOCK_FRAMES (LOCK_FRAMES),
    .LOSS_FRAMES (LOSS_FRAMES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .fsync       (fsync),
    .y           (y),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
`ifdef TDM_RX_PARITY_EN
    .par_err     (par_err),
`endif
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int total  = 0;
  int passed = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
  endtask

  // ---------------- reference model (frame-position arithmetic) ----------------
  typedef struct { int cyc; logic [NUM_CH-1:0] y; bit perr; } frame_t;
  typedef struct { int cyc; int val; } ev_t;

  frame_t fv_q[$];
  ev_t    lk_q[$];
  ev_t    slot_q[$];
  int     err_q[$];

  bit     din_hist[int];
  int     anchor   = -1;   // edge at which the current alignment's slot 0 was sampled
  int     good     = 0;
  int     miss     = 0;
  int     ok_start = 0;    // first frame-start edge whose frame may be delivered
  bit     lk       = 1'b0;

  function automatic void set_lock(int n, bit v);
    if (v != lk) lk_q.push_back('{n, int'(v)});
    lk = v;
  endfunction

  function automatic void start_align(int n);
    anchor   = n;
    good     = 1;
    miss     = 0;
    ok_start = n + FL;
    set_lock(n, LOCK_FRAMES == 1);
  endfunction

  function automatic void expect_frame(int n);
    frame_t f;
    int     start = n - FL + 1;
    for (int k = 0; k < NUM_CH; k++) f.y[k] = din_hist[start + k];
    f.cyc  = n;
    f.perr = (FL > NUM_CH) ? (din_hist[n] != ^f.y) : 1'b0;
    fv_q.push_back(f);
  endfunction

  function automatic void model(int n, bit f, bit d);
    int pos;
    din_hist[n] = d;
    if (anchor < 0) begin
      if (f) start_align(n);
    end else begin
      pos = (n - anchor) % FL;
      if (f && pos != 0) begin
        err_q.push_back(n);
        start_align(n);
      end else if (pos == 0 && f) begin
        miss = 0;
        if (!lk) begin
          good++;
          if (good >= LOCK_FRAMES) begin
            set_lock(n, 1'b1);
            ok_start = n + FL;
          end
        end
      end else if (pos == 0) begin
        err_q.push_back(n);
        miss++;
        if (!lk || miss >= LOSS_FRAMES) begin
          anchor = -1;
          good   = 0;
          miss   = 0;
          set_lock(n, 1'b0);
        end
      end else if (pos == FL - 1 && lk && (n - FL + 1) >= ok_start) begin
        expect_frame(n);
      end
    end
    slot_q.push_back('{n, (anchor < 0) ? 0 : (n + 1 - anchor) % FL});
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(bit f, bit d);
    int n;
    n     = edge_cnt + 1;
    fsync = f;
    din   = d;
    model(n, f, d);
    @(negedge clk);
  endtask

  task automatic send_frame(logic [NUM_CH-1:0] w, bit sync, bit bad_par);
    bit d;
    for (int s = 0; s < FL; s++) begin
      if (s < NUM_CH) d = w[s];
      else            d = (^w) ^ bad_par;
      drive(sync && (s == 0), d);
    end
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  function automatic logic [NUM_CH-1:0] rnd_word();
    return NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
  endfunction

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_y", 32'(y), 32'(0));
    check("rst_frame_valid", 32'(frame_valid), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_slot", 32'(slot), 32'(0));
    check("rst_sync_err", 32'(sync_err), 32'(0));
    anchor = -1;
    good   = 0;
    miss   = 0;
    lk     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  frame_t            fh;
  ev_t               eh;
  int                tmp;
  bit                exp_err, exp_fv, exp_pe, exp_lk;
  logic [NUM_CH-1:0] exp_y = '0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      exp_lk = 1'b0;
      exp_y  = '0;
    end else begin
      if (slot_q.size() != 0 && slot_q[0].cyc == edge_cnt) begin
        eh = slot_q.pop_front();
        check("slot", 32'(slot), 32'(eh.val));
      end
      exp_err = 1'b0;
      if (err_q.size() != 0 && err_q[0] == edge_cnt) begin
        tmp     = err_q.pop_front();
        exp_err = 1'b1;
      end
      check("sync_err", 32'(sync_err), 32'(exp_err));
      exp_fv = 1'b0;
      exp_pe = 1'b0;
      if (fv_q.size() != 0 && fv_q[0].cyc == edge_cnt) begin
        fh = fv_q.pop_front();
        if (fh.perr) exp_pe = 1'b1;
        else begin
          exp_fv = 1'b1;
          exp_y  = fh.y;
        end
      end
      check("frame_valid", 32'(frame_valid), 32'(exp_fv));
`ifdef TDM_RX_PARITY_EN
      check("par_err", 32'(par_err), 32'(exp_pe));
`endif
      check("y", 32'(y), 32'(exp_y));
      if (lk_q.size() != 0 && lk_q[0].cyc == edge_cnt) begin
        eh     = lk_q.pop_front();
        exp_lk = (eh.val != 0);
      end
      check("locked", 32'(locked), 32'(exp_lk));
    end
  end

  // ---------------- sequence ----------------
  initial begin
    int r;
    rst   = 1'b1;
    fsync = 1'b0;
    din   = 1'b0;
    repeat (2) @(negedge clk);
    check("init_y", 32'(y), 32'(0));
    check("init_locked", 32'(locked), 32'(0));
    check("init_slot", 32'(slot), 32'(0));
    check("init_frame_valid", 32'(frame_valid), 32'(0));
    check("init_sync_err", 32'(sync_err), 32'(0));
    rst = 1'b0;

    idle(3);
    repeat (4) send_frame(4'b1010, 1'b1, 1'b0);
    repeat (3) send_frame(4'b0110, 1'b1, 1'b0);

    // single dropped marker (flywheel), then two in a row (lock lost)
    send_frame(rnd_word(), 1'b0, 1'b0);
    repeat (3) send_frame(rnd_word(), 1'b1, 1'b0);
    repeat (2) send_frame(rnd_word(), 1'b0, 1'b0);
    repeat (4) send_frame(rnd_word(), 1'b1, 1'b0);

    // marker shifted to slot 2
    drive(1'b1, 1'($urandom_range(0, 1)));
    drive(1'b0, 1'($urandom_range(0, 1)));
    repeat (5) send_frame(rnd_word(), 1'b1, 1'b0);

`ifdef TDM_RX_PARITY_EN
    send_frame(4'b0111, 1'b1, 1'b0);
    send_frame(4'b0111, 1'b1, 1'b1);
    send_frame(rnd_word(), 1'b1, 1'b0);
`endif

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 15);
      if (r == 1) repeat ($urandom_range(1, FL - 1)) drive(1'b0, 1'($urandom_range(0, 1)));
      send_frame(rnd_word(), r != 0, r == 2);
    end

    // reset in the middle of a locked frame
    repeat (4) send_frame(rnd_word(), 1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    do_reset();
    repeat (5) send_frame(rnd_word(), 1'b1, 1'b0);
    idle(2 * FL);

    check("pending_frames", 32'(fv_q.size()), 32'(0));
    check("pending_errs", 32'(err_q.size()), 32'(0));
    check("pending_lock", 32'(lk_q.size()), 32'(0));
    check("pending_slots", 32'(slot_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
